text_line_renderer: RTL and testbench

TEXT_LINE_RENDERER -- requirements
Module: text_line_renderer

---
 rtl/text_line_renderer.sv | 167 ++++++++++++++++
 tb/tb_text_line_renderer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/text_line_renderer.sv
// Renders the text line "Count=DDDD" as a 1-bit pixel stream, scanning glyph
// rows top to bottom and fetching each glyph row from an external font ROM.
module text_line_renderer #(
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] digits,
  output logic [4:0]  char_code,
  output logic [2:0]  row,
  input  logic [7:0]  bitmap,
  output logic        pix_valid,
  output logic        pix_data,
  input  logic        pix_ready,
  output logic        line_last,
  output logic        frame_last,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fsm_state
);

  // Stream handshake: a pixel transfers on a rising edge where pix_valid and
  // pix_ready are both 1; while pix_valid=1 and pix_ready=0, pix_data,
  // line_last and frame_last hold, and pix_valid is never withdrawn.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [4:0] GLYPH_DASH  = 5'd12;
  localparam logic [4:0] GLYPH_SPACE = 5'd13;
  localparam logic [4:0] GLYPH_C     = 5'd14;

  state_t      state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic [2:0]  row_q, row_d;
  logic [3:0]  char_q, char_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;

  logic [3:0]  d3, d2, d1, d0;
  logic        blank3, blank2, blank1;
  logic [4:0]  code_c;
  logic        last_bit;
  logic        last_char;
  logic        last_row;

  function automatic logic [4:0] digit_glyph(input logic [3:0] d, input logic blank);
    if (blank) begin
      return GLYPH_SPACE;
    end else if (d <= 4'd9) begin
      return {1'b0, d};
    end else begin
      return GLYPH_DASH;
    end
  endfunction

  assign d3 = digits_q[15:12];
  assign d2 = digits_q[11:8];
  assign d1 = digits_q[7:4];
  assign d0 = digits_q[3:0];

  // Blanking runs from the most significant digit and stops at the first
  // non-zero nibble; a '-' digit is non-zero, so it stops blanking too.
  assign blank3 = (BLANK_LZ != 0) && (d3 == 4'd0);
  assign blank2 = blank3 && (d2 == 4'd0);
  assign blank1 = blank2 && (d1 == 4'd0);

  always_comb begin
    code_c = GLYPH_C;
    case (char_q)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: code_c = GLYPH_C + {1'b0, char_q};
      4'd6:    code_c = digit_glyph(d3, blank3);
      4'd7:    code_c = digit_glyph(d2, blank2);
      4'd8:    code_c = digit_glyph(d1, blank1);
      4'd9:    code_c = digit_glyph(d0, 1'b0);
      default: code_c = GLYPH_C;
    endcase
  end

  assign last_bit  = (bit_q == 3'd7);
  assign last_char = (char_q == 4'd9);
  assign last_row  = (row_q == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      digits_q <= '0;
      row_q    <= '0;
      char_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      row_q    <= row_d;
      char_q   <= char_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    row_d    = row_q;
    char_d   = char_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          digits_d = digits;
          row_d    = 3'd0;
          char_d   = 4'd0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        shreg_d = bitmap;
        bit_d   = 3'd0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (pix_ready) begin
          shreg_d = {shreg_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (last_bit) begin
            if (!last_char) begin
              char_d  = char_q + 4'd1;
              state_d = S_FETCH;
            end else if (!last_row) begin
              char_d  = 4'd0;
              row_d   = row_q + 3'd1;
              state_d = S_FETCH;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Flags are pure functions of registered state, so they cannot move
  // while a pixel is stalled waiting for pix_ready.
  assign char_code  = code_c;
  assign row        = row_q;
  assign pix_valid  = (state_q == S_SHIFT);
  assign pix_data   = pix_valid && shreg_q[7];
  assign line_last  = pix_valid && last_bit && last_char;
  assign frame_last = line_last && last_row;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_text_line_renderer.sv
// Randomized bench for text_line_renderer: a behavioural font and text model
// predicts every pixel, and a second instance covers BLANK_LZ=0.
module tb_text_line_renderer;

  localparam int W = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] digits;
  logic        pix_ready;

  logic [4:0]  char_code;
  logic [2:0]  row;
  logic [7:0]  bitmap;
  logic        pix_valid, pix_data, line_last, frame_last, busy, done;
  logic [1:0]  fsm_state;

  logic [4:0]  nb_char_code;
  logic [2:0]  nb_row;
  logic [7:0]  nb_bitmap;
  logic        nb_pix_valid, nb_pix_data, nb_line_last, nb_frame_last;
  logic        nb_busy, nb_done;
  logic [1:0]  nb_fsm_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int hs_cnt, ll_cnt, fl_cnt, done_cnt;
  int first_valid_rel, done_rel;
  bit rnd_mode = 1'b0;
  logic [15:0] cur_digits;

  // expected pixel entry: {code[4:0], row[2:0], line_last, frame_last, pixel}
  logic [W-1:0] exp_q[$];

  // ---------------- behavioural model ----------------
  function automatic logic [7:0] font(input logic [4:0] code, input logic [2:0] r);
    logic [7:0] v;
    if (code == 5'd14 && r == 3'd0) return 8'h3C;
    v = (8'(code) * 8'd29) ^ (8'(r) * 8'd83) ^ 8'hA5;
    return v;
  endfunction

  function automatic logic [4:0] code_of(input logic [15:0] dg, input int ch, input bit blz);
    int n;
    logic [3:0] nib;
    bit blank;
    if (ch < 6) return 5'(14 + ch);
    n = 9 - ch;
    nib = dg[4*n +: 4];
    blank = blz && (n > 0);
    for (int k = 3; k >= n; k--) begin
      if (dg[4*k +: 4] != 4'd0) blank = 1'b0;
    end
    if (blank) return 5'd13;
    if (nib <= 4'd9) return {1'b0, nib};
    return 5'd12;
  endfunction

  assign bitmap    = font(char_code, row);
  assign nb_bitmap = font(nb_char_code, nb_row);

  // ---------------- DUTs ----------------
  text_line_renderer #(.BLANK_LZ(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .digits(digits),
    .char_code(char_code), .row(row), .bitmap(bitmap),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .line_last(line_last), .frame_last(frame_last),
    .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  text_line_renderer #(.BLANK_LZ(0)) u_dut_nb (
    .clk(clk), .rst(rst), .start(start), .digits(digits),
    .char_code(nb_char_code), .row(nb_row), .bitmap(nb_bitmap),
    .pix_valid(nb_pix_valid), .pix_data(nb_pix_data), .pix_ready(pix_ready),
    .line_last(nb_line_last), .frame_last(nb_frame_last),
    .busy(nb_busy), .done(nb_done), .fsm_state(nb_fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      pix_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [4:0]   nb_code;
    logic [7:0]   nb_bm;
    int r, c, b;
    if (!rst) begin
      if (done) begin
        done_cnt++;
        done_rel = cyc - start_cyc + 1;
      end
      if (pix_valid) begin
        if (first_valid_rel == 0) first_valid_rel = cyc - start_cyc + 1;
        if (exp_q.size() == 0) begin
          check("extra_pixel", 32'd1, 32'd0);
        end else begin
          e = exp_q[0];
          check("char_code", 32'(char_code), 32'(e[10:6]));
          check("row", 32'(row), 32'(e[5:3]));
          check("line_last", 32'(line_last), 32'(e[2]));
          check("frame_last", 32'(frame_last), 32'(e[1]));
          check("pix_data", 32'(pix_data), 32'(e[0]));
          r = hs_cnt / 80;
          c = (hs_cnt / 8) % 10;
          b = 7 - (hs_cnt % 8);
          nb_code = code_of(cur_digits, c, 1'b0);
          nb_bm = font(nb_code, 3'(r));
          check("nb_valid", 32'(nb_pix_valid), 32'd1);
          check("nb_char_code", 32'(nb_char_code), 32'(nb_code));
          check("nb_pix_data", 32'(nb_pix_data), 32'(nb_bm[b]));
          if (pix_ready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
            if (line_last) ll_cnt++;
            if (frame_last) fl_cnt++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_line(input logic [15:0] dg, input bit rnd, input bit poke, input int abort_at);
    logic [7:0] bm;
    logic [4:0] code;
    bit poked = 1'b0;
    bit aborted = 1'b0;
    exp_q.delete();
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 10; c++) begin
        code = code_of(dg, c, 1'b1);
        bm = font(code, 3'(r));
        for (int b = 7; b >= 0; b--) begin
          exp_q.push_back({code, 3'(r), (c == 9 && b == 0), (c == 9 && b == 0 && r == 7), bm[b]});
        end
      end
    end
    cur_digits = dg;
    rnd_mode = rnd;
    hs_cnt = 0; ll_cnt = 0; fl_cnt = 0; done_cnt = 0;
    first_valid_rel = 0; done_rel = 0;
    @(posedge clk); #1;
    start = 1'b1;
    digits = dg;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    digits = 16'($urandom);
    for (int k = 0; k < 6000 && done_cnt == 0 && !aborted; k++) begin
      if (abort_at > 0 && hs_cnt >= abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(pix_valid), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        aborted = 1'b1;
      end else begin
        @(posedge clk); #1;
        start = poke && !poked && (hs_cnt >= 250);
        if (start) poked = 1'b1;
        digits = 16'($urandom);
      end
    end
    start = 1'b0;
    if (aborted) begin
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
      exp_q.delete();
    end else begin
      check("done_seen", 32'(done_cnt), 32'd1);
      repeat (4) @(posedge clk);
      #1;
      check("done_once", 32'(done_cnt), 32'd1);
      check("idle_after", 32'(busy), 32'd0);
      check("handshakes", 32'(hs_cnt), 32'd640);
      check("line_lasts", 32'(ll_cnt), 32'd8);
      check("frame_lasts", 32'(fl_cnt), 32'd1);
      check("pixels_left", 32'(exp_q.size()), 32'd0);
      check("first_valid_cycle", 32'(first_valid_rel), 32'd2);
      if (!rnd) check("done_cycle", 32'(done_rel), 32'd721);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    digits = 16'h0;
    pix_ready = 1'b1;
    cur_digits = 16'h0;
    hs_cnt = 0; ll_cnt = 0; fl_cnt = 0; done_cnt = 0;
    first_valid_rel = 0; done_rel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_line_last", 32'(line_last), 32'd0);
    check("rst_frame_last", 32'(frame_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_char_code", 32'(char_code), 32'd14);
    check("rst_row", 32'(row), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_line(16'h0123, 1'b0, 1'b0, 0);
    run_line(16'h0000, 1'b0, 1'b0, 0);
    run_line(16'h0A05, 1'b1, 1'b0, 0);
    run_line(16'($urandom), 1'b1, 1'b1, 0);
    run_line(16'($urandom), 1'b0, 1'b0, 200);
    run_line(16'h00F0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 2; i++) run_line(16'($urandom), 1'b1, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
